// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - control bus between the sequencer and the 16-bit datapath
interface alu_sequencer_if #(
    parameter int PC_W = 7,
    parameter int DA_W = 8,
    parameter int RA_W = 4
);
    logic [15:0]     IR_Data;
    logic [PC_W-1:0] PC_Addr;
    logic [DA_W-1:0] D_Addr;
    logic            D_Wr;
    logic            RF_s;
    logic [RA_W-1:0] RF_W_addr;
    logic            RF_W_en;
    logic [RA_W-1:0] RF_Ra_addr;
    logic [RA_W-1:0] RF_Rb_addr;
    logic [2:0]      ALU_Sel;
    logic [3:0]      State;
    logic            Halted;

    modport master (
        input  IR_Data,
        output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_Sel, State, Halted
    );

    modport slave (
        output IR_Data,
        input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_Sel, State, Halted
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multicycle fetch/decode/execute control FSM for the 16-bit datapath
module alu_sequencer #(
    parameter int PC_W = 7,
    parameter int DA_W = 8,
    parameter int RA_W = 4
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    alu_sequencer_if.master      bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ALU_OP = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_MOV   = 4'hA;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0]      opcode;
    logic [2:0]      alu_sel_dec;
    logic            is_alu_op;

    logic [DA_W-1:0] d_addr;
    logic            d_wr;
    logic            rf_s;
    logic [RA_W-1:0] rf_w_addr;
    logic            rf_w_en;
    logic [RA_W-1:0] rf_ra_addr;
    logic [RA_W-1:0] rf_rb_addr;
    logic [2:0]      alu_sel;
    logic            halted;

    assign opcode = ir_q[15:12];

    // Map opcode to ALU select; is_alu_op also picks which opcodes take the ALU_OP path
    always_comb begin
        alu_sel_dec = 3'd0;
        is_alu_op   = 1'b1;
        case (opcode)
            OP_ADD:  alu_sel_dec = 3'd1;
            OP_SUB:  alu_sel_dec = 3'd2;
            OP_XOR:  alu_sel_dec = 3'd4;
            OP_OR:   alu_sel_dec = 3'd5;
            OP_AND:  alu_sel_dec = 3'd6;
            OP_INC:  alu_sel_dec = 3'd7;
            OP_MOV:  alu_sel_dec = 3'd3;
            default: is_alu_op   = 1'b0;
        endcase
    end

    // State, PC and IR registers; reset lands in INIT so every enable drops at once
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; PC and IR only change in FETCH, PC wraps naturally at 2**PC_W
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.IR_Data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu_op) begin
                    state_d = S_ALU_OP;
                end else begin
                    case (opcode)
                        OP_STORE: state_d = S_STORE;
                        OP_LOAD:  state_d = S_LOAD_A;
                        OP_HALT:  state_d = S_HALT;
                        OP_NOOP:  state_d = S_NOOP;
                        default:  state_d = S_NOOP;
                    endcase
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ALU_OP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore control outputs decoded from state and IR; everything idles at 0 by default
    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_sel    = 3'd0;
        halted     = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                d_addr    = DA_W'(ir_q[11:4]);
                rf_s      = 1'b1;
                rf_w_addr = RA_W'(ir_q[3:0]);
            end
            S_LOAD_B: begin
                // Synchronous memory data is valid now, so commit the register write
                d_addr    = DA_W'(ir_q[11:4]);
                rf_s      = 1'b1;
                rf_w_addr = RA_W'(ir_q[3:0]);
                rf_w_en   = 1'b1;
            end
            S_STORE: begin
                // Write data comes from register file port A
                d_addr     = DA_W'(ir_q[11:4]);
                rf_ra_addr = RA_W'(ir_q[3:0]);
                d_wr       = 1'b1;
            end
            S_ALU_OP: begin
                rf_ra_addr = RA_W'(ir_q[11:8]);
                rf_rb_addr = RA_W'(ir_q[7:4]);
                rf_w_addr  = RA_W'(ir_q[3:0]);
                rf_w_en    = 1'b1;
                alu_sel    = alu_sel_dec;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PC_Addr    = pc_q;
    assign bus.D_Addr     = d_addr;
    assign bus.D_Wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_W_addr  = rf_w_addr;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_Ra_addr = rf_ra_addr;
    assign bus.RF_Rb_addr = rf_rb_addr;
    assign bus.ALU_Sel    = alu_sel;
    assign bus.State      = state_q;
    assign bus.Halted     = halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    logic [6:0]  mpc;
    logic [37:0] exp_v;

    alu_sequencer_if #(.PC_W(7), .DA_W(8), .RA_W(4)) bus ();

    alu_sequencer #(.PC_W(7), .DA_W(8), .RA_W(4)) dut (
        .Clk    (clk),
        .ResetN (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [37:0] obs = {bus.State, bus.PC_Addr, bus.D_Addr, bus.D_Wr, bus.RF_s,
                       bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr,
                       bus.ALU_Sel, bus.Halted};

    function automatic logic [2:0] sel_of(input logic [3:0] op);
        case (op)
            4'h3: return 3'd1;
            4'h4: return 3'd2;
            4'h6: return 3'd4;
            4'h7: return 3'd5;
            4'h8: return 3'd6;
            4'h9: return 3'd7;
            4'hA: return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit is_alu(input logic [3:0] op);
        return (op == 4'h3) || (op == 4'h4) || (op >= 4'h6 && op <= 4'hA);
    endfunction

    // phase 0 = fetch, 1 = decode, 2 = first execute cycle, 3 = second load cycle
    function automatic logic [37:0] exp_vec(input int phase, input logic [15:0] ir,
                                            input logic [6:0] pc);
        logic [3:0] st, wa, ra, rb;
        logic [7:0] da;
        logic       dw, rs, we, h;
        logic [2:0] sl;
        logic [3:0] op;
        op = ir[15:12];
        st = 4'd0; wa = 4'd0; ra = 4'd0; rb = 4'd0; da = 8'd0;
        dw = 1'b0; rs = 1'b0; we = 1'b0; h = 1'b0; sl = 3'd0;
        if (phase == 0) st = 4'd1;
        else if (phase == 1) st = 4'd2;
        else if (op == 4'h2) begin
            st = (phase == 2) ? 4'd4 : 4'd5;
            da = ir[11:4]; rs = 1'b1; wa = ir[3:0]; we = (phase == 3);
        end else if (op == 4'h1) begin
            st = 4'd6; da = ir[11:4]; ra = ir[3:0]; dw = 1'b1;
        end else if (op == 4'h5) begin
            st = 4'd8; h = 1'b1;
        end else if (is_alu(op)) begin
            st = 4'd7; ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1; sl = sel_of(op);
        end else begin
            st = 4'd3;
        end
        return {st, pc, da, dw, rs, wa, we, ra, rb, sl, h};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.IR_Data = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mpc = 7'd0;
    endtask

    task automatic run_instr(input logic [15:0] ir, input string tag);
        logic [3:0] op;
        op = ir[15:12];
        bus.IR_Data = ir;
        total_cnt++;
        exp_v = exp_vec(0, ir, mpc);
        if (obs !== exp_v) $display("FAIL %s fetch: got %h want %h", tag, obs, exp_v);
        else pass_cnt++;
        @(posedge clk);
        #1 bus.IR_Data = 16'($urandom);
        mpc = mpc + 7'd1;
        @(negedge clk);
        total_cnt++;
        exp_v = exp_vec(1, ir, mpc);
        if (obs !== exp_v) $display("FAIL %s decode: got %h want %h", tag, obs, exp_v);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        exp_v = exp_vec(2, ir, mpc);
        if (obs !== exp_v) $display("FAIL %s exec: got %h want %h", tag, obs, exp_v);
        else pass_cnt++;
        if (op == 4'h2) begin
            @(negedge clk);
            total_cnt++;
            exp_v = exp_vec(3, ir, mpc);
            if (obs !== exp_v) $display("FAIL %s load_b: got %h want %h", tag, obs, exp_v);
            else pass_cnt++;
        end
        if (op != 4'h5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.IR_Data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.State, bus.PC_Addr, bus.D_Wr, bus.RF_W_en, bus.ALU_Sel} !== 16'h0000)
            $display("FAIL reset_state: got st=%0d pc=%0d dwr=%b wen=%b sel=%0d want all 0",
                     bus.State, bus.PC_Addr, bus.D_Wr, bus.RF_W_en, bus.ALU_Sel);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.State !== 4'd0) $display("FAIL reset_init: got %0d want 0", bus.State);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.State !== 4'd1) $display("FAIL reset_fetch: got %0d want 1", bus.State);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.State !== 4'd2 || bus.PC_Addr !== 7'd1)
            $display("FAIL reset_decode: got st=%0d pc=%0d want st=2 pc=1", bus.State, bus.PC_Addr);
        else pass_cnt++;
    endtask

    task automatic test_add();
        do_reset();
        run_instr(16'h3123, "add");
        run_instr(16'h0000, "after_add");
    endtask

    task automatic test_load_store();
        do_reset();
        run_instr(16'h20A5, "load");
        run_instr(16'h10B5, "store");
        run_instr(16'h0000, "after_store");
    endtask

    task automatic test_opcode_sweep();
        logic [3:0] ops [6];
        ops = '{4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
        do_reset();
        foreach (ops[i]) run_instr({ops[i], 12'($urandom)}, $sformatf("sweep_op%0h", ops[i]));
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5) op = 4'h2;
            run_instr({op, 12'($urandom)}, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(16'h3456, "pre_halt");
        run_instr(16'h5000, "halt");
        for (int i = 0; i < 20; i++) begin
            bus.IR_Data = 16'($urandom);
            @(negedge clk);
            total_cnt++;
            exp_v = exp_vec(2, 16'h5000, mpc);
            if (obs !== exp_v) $display("FAIL halt_hold%0d: got %h want %h", i, obs, exp_v);
            else pass_cnt++;
        end
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.State !== 4'd0 || bus.PC_Addr !== 7'd0 || bus.Halted !== 1'b0)
            $display("FAIL halt_reset: got st=%0d pc=%0d h=%b want 0 0 0",
                     bus.State, bus.PC_Addr, bus.Halted);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        run_instr(16'h0000, "pre_load");
        bus.IR_Data = 16'h20A5;
        @(negedge clk);
        bus.IR_Data = 16'h0000;
        @(negedge clk);
        total_cnt++;
        if (bus.State !== 4'd4) $display("FAIL midload_in_load_a: got %0d want 4", bus.State);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.State !== 4'd0 || bus.RF_W_en !== 1'b0 || bus.PC_Addr !== 7'd0)
            $display("FAIL midload_async: got st=%0d wen=%b pc=%0d want 0 0 0",
                     bus.State, bus.RF_W_en, bus.PC_Addr);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst_n = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (bus.RF_W_en !== 1'b0 || bus.D_Wr !== 1'b0)
                $display("FAIL midload_no_write%0d: got wen=%b dwr=%b want 0 0",
                         i, bus.RF_W_en, bus.D_Wr);
            else pass_cnt++;
        end
    endtask

    task automatic test_pc_wrap();
        logic [3:0] op;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(11, 15));
            run_instr({op, 12'($urandom)}, $sformatf("wrap%0d", i));
        end
        total_cnt++;
        if (bus.PC_Addr !== 7'd0 || bus.State !== 4'd1)
            $display("FAIL pc_wrap: got pc=%0d st=%0d want pc=0 st=1", bus.PC_Addr, bus.State);
        else pass_cnt++;
        run_instr(16'h9ABC, "post_wrap");
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        mpc = 7'd0;
        rst_n = 1'b0;
        bus.IR_Data = 16'h0000;
        test_reset();
        test_add();
        test_load_store();
        test_opcode_sweep();
        test_random();
        test_halt();
        test_reset_mid_load();
        test_pc_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
